// File: rtl/dram_rd_arbiter_pkg.sv
// dram_rd_arbiter_pkg: shared parameters, FSM states and 4KB-safe burst sizing for the DRAM read arbiter
package dram_rd_arbiter_pkg;
  localparam int NREQ = 4;
  localparam int A = 32;
  localparam int D = 32;
  localparam int I = 4;
  localparam int L = 8;
  localparam int MAX_BURST = 16;
  localparam int LENW = 16;
  localparam int BPB = D / 8;
  localparam int PW = $clog2(NREQ);
  localparam int BW = L + 1;
  localparam int REQ_IFM = 0;
  localparam int REQ_FILT = 1;
  localparam int REQ_BIAS = 2;
  localparam int REQ_SCALE = 3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_SIZE = 3'($clog2(BPB));
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ADDR, S_DATA, S_FIN} state_t;
  // beats left before the next 4KB page, clipped to the job remainder and MAX_BURST
  function automatic logic [BW-1:0] burst_len(input logic [A-1:0] addr, input logic [LENW-1:0] rem);
    logic [31:0] b;
    b = (32'd4096 - {20'd0, addr[11:0]}) / 32'(BPB);
    b = (32'(rem) < b) ? 32'(rem) : b;
    b = (32'(MAX_BURST) < b) ? 32'(MAX_BURST) : b;
    return BW'(b);
  endfunction
endpackage

// File: rtl/dram_rd_arbiter_if.sv
// dram_rd_arbiter_if: loader job/beat signals plus the AXI4 AR/R channels of the shared read master
interface dram_rd_arbiter_if
  import dram_rd_arbiter_pkg::*;
;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][A-1:0]    req_addr;
  logic [NREQ-1:0][LENW-1:0] req_beats;
  logic [D-1:0]              rd_data;
  logic [NREQ-1:0]           rd_valid;
  logic [NREQ-1:0]           rd_ready;
  logic [NREQ-1:0]           job_done;
  logic                      busy;
  logic                      err;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [A-1:0]              m_araddr;
  logic [I-1:0]              m_arid;
  logic [L-1:0]              m_arlen;
  logic [2:0]                m_arsize;
  logic [1:0]                m_arburst;
  logic                      m_rvalid;
  logic                      m_rready;
  logic [D-1:0]              m_rdata;
  logic [I-1:0]              m_rid;
  logic                      m_rlast;
  logic [1:0]                m_rresp;
  modport master (
    input  req_valid, req_addr, req_beats, rd_ready, m_arready, m_rvalid, m_rdata, m_rid, m_rlast, m_rresp,
    output req_ready, rd_data, rd_valid, job_done, busy, err,
           m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready
  );
  modport slave (
    output req_valid, req_addr, req_beats, rd_ready, m_arready, m_rvalid, m_rdata, m_rid, m_rlast, m_rresp,
    input  req_ready, rd_data, rd_valid, job_done, busy, err,
           m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready
  );
endinterface

// File: rtl/dram_rd_arbiter_rr.sv
// dram_rd_arbiter_rr: rotating-priority one-hot picker; the first request at or after i_ptr wins
module dram_rd_arbiter_rr
  import dram_rd_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);
  int j;
  // scan from the farthest offset down so the nearest request to i_ptr is written last
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    j = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(i_ptr) + i) % NREQ;
      if (i_req[j]) begin
        o_gnt = NREQ'(1) << j;
        o_idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/dram_rd_arbiter.sv
// dram_rd_arbiter: round-robin job arbiter sharing one AXI4 read master, 4KB-safe burst splitting
module dram_rd_arbiter
  import dram_rd_arbiter_pkg::*;
(
  input logic               i_clk,
  input logic               i_rstn,
  dram_rd_arbiter_if.master bus
);
  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_k;
  logic [A-1:0]    r_addr;
  logic [LENW-1:0] r_rem;
  logic [L-1:0]    r_arlen;
  logic [BW-1:0]   r_cnt;
  logic            r_arvalid;
  logic            r_err;
  logic [NREQ-1:0] r_req_ready;
  logic [NREQ-1:0] r_rd_valid;
  logic [NREQ-1:0] r_done;
  logic [D-1:0]    r_rd_data;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_own;
  logic [BW-1:0]   w_burst;
  logic            w_rready;
  logic            w_rhs;
  dram_rd_arbiter_rr u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
  assign w_own    = NREQ'(1) << r_k;
  assign w_burst  = BW'(r_arlen) + BW'(1);
  assign w_rready = (r_state == S_DATA) && bus.rd_ready[r_k];
  assign w_rhs    = w_rready && bus.m_rvalid;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_k         <= '0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_arlen     <= '0;
      r_cnt       <= '0;
      r_arvalid   <= 1'b0;
      r_err       <= 1'b0;
      r_req_ready <= '0;
      r_rd_valid  <= '0;
      r_done      <= '0;
      r_rd_data   <= '0;
    end else begin
      r_req_ready <= '0;
      r_rd_valid  <= '0;
      r_done      <= '0;
      if (w_rhs) begin
        r_rd_data  <= bus.m_rdata;
        r_rd_valid <= w_own;
        r_err      <= r_err || (bus.m_rresp != AXI_RESP_OKAY);
      end
      case (r_state)
        S_IDLE: if (|bus.req_valid) begin
          r_k         <= w_idx;
          r_ptr       <= PW'((int'(w_idx) + 1) % NREQ);
          r_addr      <= bus.req_addr[w_idx];
          r_rem       <= bus.req_beats[w_idx];
          r_req_ready <= w_gnt;
          r_state     <= S_GRANT;
        end
        S_GRANT: begin
          r_cnt <= '0;
          if (r_rem == '0) r_state <= S_FIN;
          else begin
            r_arlen   <= L'(burst_len(r_addr, r_rem) - BW'(1));
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: if (bus.m_arready) begin
          r_arvalid <= 1'b0;
          r_state   <= S_DATA;
        end
        S_DATA: if (w_rhs) begin
          r_cnt <= r_cnt + BW'(1);
          if (bus.m_rlast) begin
            r_addr  <= r_addr + A'(w_burst) * A'(BPB);
            r_rem   <= r_rem - LENW'(w_burst);
            r_state <= (r_rem == LENW'(w_burst)) ? S_FIN : S_GRANT;
          end
        end
        S_FIN: begin
          r_done  <= w_own;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.req_ready = r_req_ready;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.job_done  = r_done;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.err       = r_err;
  assign bus.m_arvalid = r_arvalid;
  assign bus.m_araddr  = r_addr;
  assign bus.m_arid    = I'(r_k);
  assign bus.m_arlen   = r_arlen;
  assign bus.m_arsize  = AXI_SIZE;
  assign bus.m_arburst = AXI_BURST_INCR;
  assign bus.m_rready  = w_rready;
  for (genvar g = 0; g < NREQ; g++) begin : g_hold
    assert property (@(posedge i_clk) disable iff (!i_rstn)
      bus.req_valid[g] && !bus.req_ready[g] |=> bus.req_valid[g] || bus.req_ready[g])
      else $error("req_valid dropped before req_ready");
  end
  assert property (@(posedge i_clk) disable iff (!i_rstn)
    (r_state == S_DATA) && bus.m_rvalid |-> bus.m_rid == I'(r_k))
    else $error("RID does not match owner");
  assert property (@(posedge i_clk) disable iff (!i_rstn)
    w_rhs |-> bus.m_rlast == (r_cnt == w_burst - BW'(1)))
    else $error("RLAST count mismatch");
endmodule

// File: tb/tb_dram_rd_arbiter.sv
// tb_dram_rd_arbiter: scoreboard bench with an AXI read slave model and loader request driver
module tb_dram_rd_arbiter;
  import dram_rd_arbiter_pkg::*;
  typedef struct { int k; logic [31:0] d; } beat_t;
  typedef struct { logic [31:0] a; int len; int id; } ar_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int post_cnt [NREQ];
  int gnt_cnt [NREQ];
  int beats_seen [NREQ];
  int ar_delay = 0;
  bit rdy_rand = 1'b0;
  bit rgap = 1'b0;
  bit resp_err = 1'b0;
  beat_t exp_beat [$];
  ar_t exp_ar [$];
  int exp_grant [$];
  int exp_done [$];
  dram_rd_arbiter_if bus ();
  dram_rd_arbiter dut (.i_clk(clk), .i_rstn(rstn), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction
  task automatic idle_bus();
    bus.m_arready = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rlast = 1'b0;
  endtask
  task automatic post(int k, logic [31:0] a, int beats, bit auto_ar);
    logic [31:0] ad;
    int rem, b;
    bus.req_addr[k] = a;
    bus.req_beats[k] = LENW'(beats);
    post_cnt[k]++;
    exp_grant.push_back(k);
    exp_done.push_back(k);
    for (int i = 0; i < beats; i++) exp_beat.push_back('{k, mem(a + 32'(4 * i))});
    ad = a;
    rem = beats;
    while (auto_ar && rem > 0) begin
      b = (4096 - int'(ad[11:0])) / 4;
      if (b > 16) b = 16;
      if (b > rem) b = rem;
      exp_ar.push_back('{ad, b - 1, k});
      ad += 32'(b * 4);
      rem -= b;
    end
  endtask
  // AXI read slave: one AR then its R beats per call, abandoning everything on reset
  task automatic slave_one();
    ar_t got, e;
    int w;
    @(negedge clk);
    idle_bus();
    if (!rstn || !bus.m_arvalid) return;
    got = '{bus.m_araddr, int'(bus.m_arlen), int'(bus.m_arid)};
    for (int d = 0; d < ar_delay; d++) begin
      @(negedge clk);
      if (!rstn) return;
      n_chk++;
      if (!bus.m_arvalid || bus.m_araddr !== got.a || int'(bus.m_arlen) != got.len || int'(bus.m_arid) != got.id) begin
        n_fail++;
        $display("FAIL ar_stable: got v=%b addr=%h len=%0d id=%0d want v=1 addr=%h len=%0d id=%0d",
                 bus.m_arvalid, bus.m_araddr, bus.m_arlen, bus.m_arid, got.a, got.len, got.id);
      end
    end
    bus.m_arready = 1'b1;
    @(negedge clk);
    bus.m_arready = 1'b0;
    if (!rstn) return;
    n_chk++;
    if (exp_ar.size() == 0) begin
      n_fail++;
      $display("FAIL ar_unexpected: got addr=%h len=%0d id=%0d want no AR", got.a, got.len, got.id);
    end else begin
      e = exp_ar.pop_front();
      if (got.a !== e.a || got.len != e.len || got.id != e.id) begin
        n_fail++;
        $display("FAIL ar: got addr=%h len=%0d id=%0d want addr=%h len=%0d id=%0d", got.a, got.len, got.id, e.a, e.len, e.id);
      end
    end
    n_chk++;
    if (bus.m_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_drop: got arvalid=%b want 0", bus.m_arvalid);
    end
    for (int b = 0; b <= got.len; b++) begin
      while (rgap && $urandom_range(0, 2) == 0) begin
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        if (!rstn) begin idle_bus(); return; end
      end
      bus.m_rvalid = 1'b1;
      bus.m_rdata = mem(got.a + 32'(4 * b));
      bus.m_rid = I'(got.id);
      bus.m_rlast = (b == got.len);
      bus.m_rresp = resp_err ? 2'b10 : AXI_RESP_OKAY;
      w = 0;
      while (!bus.m_rready) begin
        @(negedge clk);
        if (!rstn) begin idle_bus(); return; end
        if (++w > 500) begin
          n_chk++;
          n_fail++;
          $display("FAIL rready_timeout: got no rready after %0d cycles want handshake", w);
          idle_bus();
          return;
        end
      end
      @(negedge clk);
      if (!rstn) begin idle_bus(); return; end
    end
    idle_bus();
  endtask
  initial forever slave_one();
  initial forever begin
    @(posedge clk);
    #2;
    bus.rd_ready = rdy_rand ? NREQ'($urandom_range(0, 15)) : '1;
  end
  // loader side: req_valid[k] stays up while any posted job of k is still ungranted
  initial forever begin
    logic [NREQ-1:0] v;
    int e;
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      if (!rstn) gnt_cnt[k] = post_cnt[k];
      else if (bus.req_ready[k]) begin
        gnt_cnt[k]++;
        n_chk++;
        e = exp_grant.size() ? exp_grant.pop_front() : -1;
        if (e != k) begin
          n_fail++;
          $display("FAIL grant: got req_ready=%b want requester %0d", bus.req_ready, e);
        end
      end
      v[k] = post_cnt[k] != gnt_cnt[k];
    end
    bus.req_valid = v;
  end
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rstn && bus.rd_valid != '0) begin
      n_chk++;
      if (exp_beat.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got rd_valid=%b data=%h want none", bus.rd_valid, bus.rd_data);
      end else begin
        e = exp_beat.pop_front();
        beats_seen[e.k]++;
        if (bus.rd_valid !== (NREQ'(1) << e.k) || bus.rd_data !== e.d) begin
          n_fail++;
          $display("FAIL beat: got rd_valid=%b data=%h want rd_valid=%b data=%h",
                   bus.rd_valid, bus.rd_data, NREQ'(1) << e.k, e.d);
        end
      end
    end
  end
  initial forever begin
    int e, left;
    @(negedge clk);
    if (rstn && bus.job_done != '0) begin
      n_chk++;
      if (exp_done.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got job_done=%b want 0", bus.job_done);
      end else begin
        e = exp_done.pop_front();
        left = 0;
        foreach (exp_beat[i]) if (exp_beat[i].k == e) left++;
        if (bus.job_done !== (NREQ'(1) << e) || left != 0) begin
          n_fail++;
          $display("FAIL done: got job_done=%b beats_left=%0d want job_done=%b beats_left=0",
                   bus.job_done, left, NREQ'(1) << e);
        end
      end
    end
  end
  task automatic wait_idle(string name, int budget);
    int c = 0;
    @(negedge clk);
    while (c < budget && !(exp_done.size() == 0 && exp_beat.size() == 0 && !bus.busy && bus.req_valid == '0)) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy=%b beats_left=%0d dones_left=%0d want idle within %0d cycles",
               name, bus.busy, exp_beat.size(), exp_done.size(), budget);
    end
    n_chk++;
    if (exp_ar.size() != 0) begin
      n_fail++;
      $display("FAIL %s_ar_left: got %0d ARs missing want 0", name, exp_ar.size());
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic check_quiet(string name);
    n_chk++;
    if ({bus.req_ready, bus.rd_valid, bus.job_done, bus.busy, bus.m_arvalid, bus.m_rready,
         bus.m_araddr, bus.m_arid, bus.m_arlen, bus.rd_data, bus.err} !== '0) begin
      n_fail++;
      $display("FAIL %s_zero: got req_ready=%b rd_valid=%b done=%b busy=%b arvalid=%b rready=%b araddr=%h arlen=%h rd_data=%h err=%b want all 0",
               name, bus.req_ready, bus.rd_valid, bus.job_done, bus.busy, bus.m_arvalid, bus.m_rready,
               bus.m_araddr, bus.m_arlen, bus.rd_data, bus.err);
    end
    n_chk++;
    if (bus.m_arsize !== 3'd2 || bus.m_arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL %s_const: got arsize=%0d arburst=%b want arsize=2 arburst=01", name, bus.m_arsize, bus.m_arburst);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_rr();
    post(REQ_IFM, 32'h0000_4000, 3, 1'b1);
    post(REQ_FILT, 32'h0000_4100, 4, 1'b1);
    post(REQ_BIAS, 32'h0000_4200, 5, 1'b1);
    post(REQ_SCALE, 32'h0000_4300, 6, 1'b1);
    wait_idle("rr_all", 1000);
    post(REQ_IFM, 32'h0000_5000, 2, 1'b1);
    post(REQ_BIAS, 32'h0000_5100, 2, 1'b1);
    wait_idle("rr_two", 500);
  endtask
  task automatic test_single();
    int b0 = beats_seen[REQ_FILT];
    post(REQ_FILT, 32'h0000_1000, 40, 1'b0);
    exp_ar.push_back('{32'h0000_1000, 15, 1});
    exp_ar.push_back('{32'h0000_1040, 15, 1});
    exp_ar.push_back('{32'h0000_1080, 7, 1});
    wait_idle("single", 1000);
    n_chk++;
    if (beats_seen[REQ_FILT] - b0 != 40) begin
      n_fail++;
      $display("FAIL single_beats: got %0d want 40", beats_seen[REQ_FILT] - b0);
    end
    n_chk++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_err: got %b want 0", bus.err);
    end
  endtask
  task automatic test_4kb();
    post(REQ_BIAS, 32'h0000_0FF8, 6, 1'b0);
    exp_ar.push_back('{32'h0000_0FF8, 1, 2});
    exp_ar.push_back('{32'h0000_1000, 3, 2});
    wait_idle("4kb", 500);
  endtask
  task automatic test_back_to_back();
    ar_delay = 5;
    rdy_rand = 1'b1;
    rgap = 1'b1;
    resp_err = 1'b1;
    post(REQ_SCALE, 32'h0000_2FA0, 50, 1'b1);
    wait_idle("stress", 3000);
    n_chk++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL stress_err: got %b want 1", bus.err);
    end
    ar_delay = 0;
    rdy_rand = 1'b0;
    rgap = 1'b0;
    resp_err = 1'b0;
  endtask
  task automatic test_reset_mid();
    int b0 = beats_seen[REQ_IFM];
    int c = 0;
    bit bad = 1'b0;
    post(REQ_IFM, 32'h0000_8000, 32, 1'b1);
    while (c < 500 && beats_seen[REQ_IFM] - b0 < 3) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (c >= 500) begin
      n_fail++;
      $display("FAIL midrst_start: got %0d beats want 3 before reset", beats_seen[REQ_IFM] - b0);
    end
    #3 rstn = 1'b0;
    #1 check_quiet("midrst");
    exp_ar.delete();
    exp_beat.delete();
    exp_grant.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      bad |= (bus.job_done != '0) || bus.busy;
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL midrst_quiet: got job_done or busy after reset want none");
    end
    post(REQ_FILT, 32'h0000_9000, 5, 1'b1);
    wait_idle("midrst_next", 500);
  endtask
  task automatic test_zero();
    post(REQ_SCALE, 32'h0000_A000, 0, 1'b1);
    wait_idle("zero", 200);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_beats = '0;
    bus.rd_ready = '1;
    bus.m_rdata = '0;
    bus.m_rid = '0;
    bus.m_rresp = '0;
    idle_bus();
    for (int k = 0; k < NREQ; k++) begin
      post_cnt[k] = 0;
      beats_seen[k] = 0;
    end
    test_reset();
    test_rr();
    test_single();
    test_4kb();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test want finish before 400000");
    $fatal(1, "watchdog expired");
  end
endmodule
